mips_fetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end for the pipelined MIPS core; supersedes the single fetch pipeline register.

---
 rtl/mips_fetch_queue.sv | 94 +++++++++
 tb/tb_mips_fetch_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency imem reads and
// buffers returned words with their PCs in a small FIFO toward decode.
module mips_fetch_queue #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned IMEM_BYTES = 128,
  parameter int unsigned QDEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int unsigned AW = $clog2(IMEM_BYTES),
  localparam int unsigned CW = $clog2(QDEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [CW-1:0]   q_count
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] pend_pc;
  logic            pending;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [XLEN-1:0] fifo_instr [QDEPTH];
  logic [XLEN-1:0] fifo_pc    [QDEPTH];

  logic [CW:0] occupancy;
  logic        push;
  logic        pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit includes the in-flight read so a returning word always has a slot.
  assign occupancy   = {1'b0, count} + {{CW{1'b0}}, pending};
  assign imem_req    = rst_n & fetch_en & ~redirect_valid & (occupancy < (CW+1)'(QDEPTH));
  assign imem_addr   = fpc[AW-1:0];
  assign instr_valid = rst_n & ~redirect_valid & (count != '0);
  assign instr       = (count != '0) ? fifo_instr[rd_ptr] : '0;
  assign instr_pc    = (count != '0) ? fifo_pc[rd_ptr]    : '0;
  assign q_count     = count;
  assign push        = pending & ~redirect_valid;
  assign pop         = instr_valid & instr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc     <= RESET_PC;
      pend_pc <= '0;
      pending <= 1'b0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else if (redirect_valid) begin
      fpc     <= redirect_pc & ~XLEN'(3);
      pending <= 1'b0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      pending <= imem_req;
      if (imem_req) begin
        fpc     <= fpc + XLEN'(4);
        pend_pc <= fpc;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only entries covered by count are ever exposed.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= pend_pc;
    end
  end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Self-checking bench for mips_fetch_queue: transaction scoreboard of requested words
// (pushed on request, popped on accept) plus directed boundary checks.
module tb_mips_fetch_queue;

  localparam int unsigned XLEN = 32;
  localparam int unsigned QD   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b1;
  logic        imem_req;
  logic [6:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  q_count;

  mips_fetch_queue #(
    .XLEN(XLEN), .IMEM_BYTES(128), .QDEPTH(QD), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .q_count(q_count)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [32];
  initial for (int i = 0; i < 32; i++) imem[i] = {16'hC0DE, 8'(i), 8'(~i)};
  always @(posedge clk) imem_rdata <= imem[imem_addr[6:2]];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct { logic [31:0] pc; logic [31:0] word; } entry_t;
  entry_t      sb[$];
  logic        inflight = 1'b0;
  logic [31:0] mpc = '0;

  // Model evaluated mid-cycle; its state update reflects the coming rising edge.
  always @(negedge clk) begin
    int    fifo_cnt;
    logic  exp_req;
    logic  exp_valid;
    entry_t e;
    if (!rst_n) begin
      chk("req_in_reset", imem_req, 0);
      chk("valid_in_reset", instr_valid, 0);
      sb.delete();
      inflight = 1'b0;
      mpc = 32'h0;
    end else begin
      fifo_cnt  = sb.size() - int'(inflight);
      exp_req   = fetch_en & ~redirect_valid & (sb.size() < QD);
      exp_valid = ~redirect_valid & (fifo_cnt > 0);
      chk("imem_req", imem_req, exp_req);
      chk("instr_valid", instr_valid, exp_valid);
      chk("q_count", q_count, fifo_cnt);
      if (fifo_cnt == 0) begin
        chk("empty_instr", instr, 0);
        chk("empty_pc", instr_pc, 0);
      end
      if (redirect_valid) begin
        sb.delete();
        inflight = 1'b0;
        mpc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (exp_valid && instr_ready) begin
          e = sb.pop_front();
          chk("instr_pc", instr_pc, e.pc);
          chk("instr", instr, e.word);
        end
        inflight = exp_req;
        if (exp_req) begin
          chk("imem_addr", imem_addr, mpc[6:0]);
          e.pc = mpc;
          e.word = imem[mpc[6:2]];
          sb.push_back(e);
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    tick(2);
    rst_n = 1'b1;
    tick(12);

    // Backpressure: FIFO fills to QDEPTH and requests stop.
    instr_ready = 1'b0;
    tick(8);
    @(negedge clk);
    chk("full_count", q_count, 4);
    chk("full_noreq", imem_req, 0);
    tick(1);
    instr_ready = 1'b1;
    tick(10);

    // Redirect with a full FIFO, ready asserted during the redirect cycle.
    instr_ready = 1'b0;
    tick(6);
    instr_ready = 1'b1;
    redirect(32'h04);
    @(negedge clk);
    chk("flush_count", q_count, 0);
    tick(8);

    // Misaligned target is forced to a word boundary.
    redirect(32'h16);
    @(negedge clk);
    chk("align_addr", imem_addr, 7'h14);
    tick(6);

    // Walk past the top of the aliased instruction memory.
    redirect(32'h78);
    tick(8);
    redirect(32'hFFFF_FFF8);
    tick(6);

    // fetch_en low: in-flight read completes, no new requests, FIFO drains.
    fetch_en = 1'b0;
    tick(6);
    @(negedge clk);
    chk("noen_noreq", imem_req, 0);
    chk("noen_drained", q_count, 0);
    tick(1);
    fetch_en = 1'b1;
    tick(4);

    // Back-to-back redirects: last one wins.
    redirect(32'h40);
    redirect(32'h20);
    tick(6);

    for (int i = 0; i < 300; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      fetch_en    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) redirect($urandom);
      else tick(1);
    end

    // Mid-operation reset with a partly full FIFO.
    fetch_en = 1'b1;
    instr_ready = 1'b0;
    redirect(32'h0);
    tick(4);
    @(negedge clk);
    chk("pre_reset_count", q_count, 3);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    @(negedge clk);
    chk("post_reset_count", q_count, 0);
    tick(1);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("restart_addr", imem_addr, 7'h00);
    tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
